// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: register addresses, write enables and
// div/branch flags in; forwarding selects, stall/flush and divider status out.
interface hazard_ctrl_if;
    logic [4:0] ID_rs_addr;
    logic [4:0] ID_rt_addr;
    logic [4:0] EX_rs_addr;
    logic [4:0] EX_rt_addr;
    logic [4:0] EX_reg_waddr;
    logic       EX_mem_read;
    logic [4:0] ME_reg_waddr;
    logic       ME_reg_we;
    logic [4:0] WB_reg_waddr;
    logic       WB_reg_we;
    logic       EX_div_start;
    logic       ID_branch_taken;

    logic [2:0] EX_fwd_rs_sel;
    logic [2:0] EX_fwd_rt_sel;
    logic       IF_stall;
    logic       ID_stall;
    logic       EX_stall;
    logic       IF_flush;
    logic       EX_flush;
    logic       ME_flush;
    logic       div_busy;
    logic       div_done;

    modport master (
        output ID_rs_addr, ID_rt_addr, EX_rs_addr, EX_rt_addr, EX_reg_waddr,
               EX_mem_read, ME_reg_waddr, ME_reg_we, WB_reg_waddr, WB_reg_we,
               EX_div_start, ID_branch_taken,
        input  EX_fwd_rs_sel, EX_fwd_rt_sel, IF_stall, ID_stall, EX_stall,
               IF_flush, EX_flush, ME_flush, div_busy, div_done
    );

    modport slave (
        input  ID_rs_addr, ID_rt_addr, EX_rs_addr, EX_rt_addr, EX_reg_waddr,
               EX_mem_read, ME_reg_waddr, ME_reg_we, WB_reg_waddr, WB_reg_we,
               EX_div_start, ID_branch_taken,
        output EX_fwd_rs_sel, EX_fwd_rt_sel, IF_stall, ID_stall, EX_stall,
               IF_flush, EX_flush, ME_flush, div_busy, div_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: EX operand forwarding, load-use bubble,
// branch flush and a multi-cycle divider stall sequencer.
module hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    div_state_t state;
    logic [5:0] cnt;
    logic       done_r;
    logic       load_use;
    logic       div_busy;
    logic       pipe_stall;

    // ME result is younger than WB data, so it takes priority.
    function automatic logic [2:0] fwd_sel(
        input logic [4:0] addr,
        input logic [4:0] me_addr,
        input logic       me_we,
        input logic [4:0] wb_addr,
        input logic       wb_we
    );
        if (addr != 5'd0 && me_we && addr == me_addr)
            return 3'b010;
        else if (addr != 5'd0 && wb_we && addr == wb_addr)
            return 3'b100;
        else
            return 3'b001;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (hz.EX_div_start) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == 6'd0) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // The stall begins in the same cycle the div reaches EX, before BUSY is entered.
    assign div_busy = !rst && ((state == IDLE && hz.EX_div_start) || state == BUSY);

    assign load_use = hz.EX_mem_read && (hz.EX_reg_waddr != 5'd0) &&
                      ((hz.EX_reg_waddr == hz.ID_rs_addr) ||
                       (hz.EX_reg_waddr == hz.ID_rt_addr));

    assign pipe_stall = div_busy || load_use;

    assign hz.EX_fwd_rs_sel = fwd_sel(hz.EX_rs_addr, hz.ME_reg_waddr, hz.ME_reg_we,
                                      hz.WB_reg_waddr, hz.WB_reg_we);
    assign hz.EX_fwd_rt_sel = fwd_sel(hz.EX_rt_addr, hz.ME_reg_waddr, hz.ME_reg_we,
                                      hz.WB_reg_waddr, hz.WB_reg_we);

    assign hz.IF_stall = pipe_stall;
    assign hz.ID_stall = pipe_stall;
    assign hz.EX_stall = div_busy;
    assign hz.ME_flush = div_busy;
    // The divider freezes EX, so a load-use bubble must not overwrite it.
    assign hz.EX_flush = load_use && !div_busy;
    assign hz.IF_flush = hz.ID_branch_taken && !pipe_stall;
    assign hz.div_busy = div_busy;
    assign hz.div_done = done_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic scored against a cycle-offset model of the divider.
module tb_hazard_ctrl;
    localparam int DIVC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    // Cycles elapsed since the current divide was accepted; -1 when idle.
    int k = -1;

    function automatic logic [7:0] obs_ctl();
        return {hif.IF_stall, hif.ID_stall, hif.EX_stall, hif.IF_flush,
                hif.EX_flush, hif.ME_flush, hif.div_busy, hif.div_done};
    endfunction

    function automatic logic [2:0] ref_fwd(input logic [4:0] a);
        if (a != 0 && hif.ME_reg_we && a == hif.ME_reg_waddr) return 3'b010;
        if (a != 0 && hif.WB_reg_we && a == hif.WB_reg_waddr) return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic [7:0] ref_ctl();
        logic busy, done, lu, stall;
        busy  = (k < 0 && hif.EX_div_start && !rst) || (k >= 1 && k <= DIVC);
        done  = (k == DIVC + 1);
        lu    = hif.EX_mem_read && hif.EX_reg_waddr != 0 &&
                (hif.EX_reg_waddr == hif.ID_rs_addr || hif.EX_reg_waddr == hif.ID_rt_addr);
        stall = busy || lu;
        return {stall, stall, busy, hif.ID_branch_taken && !stall,
                lu && !busy, busy, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) k = -1;
        else if (k < 0) k = hif.EX_div_start ? 1 : -1;
        else if (k == DIVC + 1) k = -1;
        else k++;
        @(negedge clk);
    endtask

    task automatic set_idle();
        hif.ID_rs_addr = 0; hif.ID_rt_addr = 0; hif.EX_rs_addr = 0; hif.EX_rt_addr = 0;
        hif.EX_reg_waddr = 0; hif.EX_mem_read = 0; hif.ME_reg_waddr = 0; hif.ME_reg_we = 0;
        hif.WB_reg_waddr = 0; hif.WB_reg_we = 0; hif.EX_div_start = 0; hif.ID_branch_taken = 0;
    endtask

    task automatic rand_inputs();
        hif.ID_rs_addr = 5'($urandom_range(0, 3));
        hif.ID_rt_addr = 5'($urandom_range(0, 3));
        hif.EX_rs_addr = 5'($urandom_range(0, 3));
        hif.EX_rt_addr = 5'($urandom_range(0, 3));
        hif.EX_reg_waddr = 5'($urandom_range(0, 3));
        hif.ME_reg_waddr = 5'($urandom_range(0, 3));
        hif.WB_reg_waddr = 5'($urandom_range(0, 3));
        hif.EX_mem_read = 1'($urandom_range(0, 1));
        hif.ME_reg_we = 1'($urandom_range(0, 1));
        hif.WB_reg_we = 1'($urandom_range(0, 1));
        hif.ID_branch_taken = 1'($urandom_range(0, 1));
        hif.EX_div_start = ($urandom_range(0, 5) == 0);
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1; k = -1;
        for (int c = 0; c < 4; c++) begin
            rand_inputs();
            hif.EX_div_start = 1'b0;
            #1;
            exp = ref_ctl();
            n_cmp++;
            if (obs_ctl() !== exp) begin
                n_bad++;
                $display("FAIL reset_ctl c=%0d: got %b expected %b", c, obs_ctl(), exp);
            end
            n_cmp++;
            if (hif.div_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_div_done c=%0d: got %b expected 0", c, hif.div_done);
            end
            tick();
        end
        set_idle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs_ctl() !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_idle_outputs: got %b expected %b", obs_ctl(), 8'b0);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [5:0] exp;
        set_idle();
        hif.EX_rs_addr = 5; hif.ME_reg_waddr = 5; hif.ME_reg_we = 1;
        hif.WB_reg_waddr = 5; hif.WB_reg_we = 1;
        #1;
        n_cmp++;
        if (hif.EX_fwd_rs_sel !== 3'b010) begin
            n_bad++;
            $display("FAIL fwd_me_wins: got %b expected 010", hif.EX_fwd_rs_sel);
        end
        hif.ME_reg_we = 0;
        #1;
        n_cmp++;
        if (hif.EX_fwd_rs_sel !== 3'b100) begin
            n_bad++;
            $display("FAIL fwd_wb: got %b expected 100", hif.EX_fwd_rs_sel);
        end
        hif.EX_rs_addr = 0; hif.ME_reg_waddr = 0; hif.ME_reg_we = 1; hif.WB_reg_waddr = 0;
        #1;
        n_cmp++;
        if (hif.EX_fwd_rs_sel !== 3'b001) begin
            n_bad++;
            $display("FAIL fwd_r0: got %b expected 001", hif.EX_fwd_rs_sel);
        end
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            hif.EX_div_start = 0;
            #1;
            exp = {ref_fwd(hif.EX_rs_addr), ref_fwd(hif.EX_rt_addr)};
            n_cmp++;
            if ({hif.EX_fwd_rs_sel, hif.EX_fwd_rt_sel} !== exp) begin
                n_bad++;
                $display("FAIL fwd_rand i=%0d: got %b expected %b", i,
                         {hif.EX_fwd_rs_sel, hif.EX_fwd_rt_sel}, exp);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        hif.EX_mem_read = 1; hif.EX_reg_waddr = 8; hif.ID_rt_addr = 8;
        #1;
        n_cmp++;
        if (obs_ctl() !== 8'b1100_1000) begin
            n_bad++;
            $display("FAIL load_use_stall: got %b expected %b", obs_ctl(), 8'b1100_1000);
        end
        tick();
        hif.EX_mem_read = 0; hif.EX_reg_waddr = 0;
        #1;
        n_cmp++;
        if (obs_ctl() !== 8'b0) begin
            n_bad++;
            $display("FAIL load_use_bubble: got %b expected %b", obs_ctl(), 8'b0);
        end
        set_idle();
        tick();
    endtask

    // Divide held in EX from cycle 0 through its DONE cycle.
    task automatic run_div(input string tag);
        logic [7:0] exp;
        for (int c = 0; c <= DIVC + 2; c++) begin
            hif.EX_div_start = (c <= DIVC + 1);
            #1;
            exp = (c <= DIVC) ? 8'b1110_0110 : (c == DIVC + 1) ? 8'b0000_0001 : 8'b0;
            n_cmp++;
            if (obs_ctl() !== exp) begin
                n_bad++;
                $display("FAIL %s c=%0d: got %b expected %b", tag, c, obs_ctl(), exp);
            end
            tick();
        end
        hif.EX_div_start = 0;
    endtask

    task automatic test_div();
        set_idle();
        run_div("div_seq");
    endtask

    task automatic test_div_load_use();
        logic [7:0] exp;
        set_idle();
        hif.EX_mem_read = 1; hif.EX_reg_waddr = 8; hif.ID_rs_addr = 8;
        for (int c = 0; c <= DIVC + 2; c++) begin
            hif.EX_div_start = (c <= DIVC + 1);
            #1;
            exp = ref_ctl();
            n_cmp++;
            if (obs_ctl() !== exp) begin
                n_bad++;
                $display("FAIL div_lu_model c=%0d: got %b expected %b", c, obs_ctl(), exp);
            end
            if (c == 0) begin
                n_cmp++;
                if (obs_ctl() !== 8'b1110_0110) begin
                    n_bad++;
                    $display("FAIL div_lu_start: got %b expected %b", obs_ctl(), 8'b1110_0110);
                end
            end
            if (c == DIVC + 1) begin
                n_cmp++;
                if (hif.div_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL div_lu_done: got %b expected 1", hif.div_done);
                end
            end
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic test_branch_stall();
        set_idle();
        hif.EX_mem_read = 1; hif.EX_reg_waddr = 8; hif.ID_rt_addr = 8; hif.ID_branch_taken = 1;
        #1;
        n_cmp++;
        if (obs_ctl() !== 8'b1100_1000) begin
            n_bad++;
            $display("FAIL branch_held: got %b expected %b", obs_ctl(), 8'b1100_1000);
        end
        tick();
        hif.EX_mem_read = 0; hif.EX_reg_waddr = 0;
        #1;
        n_cmp++;
        if (obs_ctl() !== 8'b0001_0000) begin
            n_bad++;
            $display("FAIL branch_flush: got %b expected %b", obs_ctl(), 8'b0001_0000);
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        set_idle();
        hif.EX_div_start = 1;
        tick();
        tick();
        // Now at cnt == 2.
        #1;
        n_cmp++;
        if (hif.div_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rmb_busy_before: got %b expected 1", hif.div_busy);
        end
        rst = 1'b1; hif.EX_div_start = 0; k = -1;
        #1;
        n_cmp++;
        if (obs_ctl() !== 8'b0) begin
            n_bad++;
            $display("FAIL rmb_abort: got %b expected %b", obs_ctl(), 8'b0);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < DIVC + 3; c++) begin
            #1;
            n_cmp++;
            if (obs_ctl() !== 8'b0) begin
                n_bad++;
                $display("FAIL rmb_no_done c=%0d: got %b expected %b", c, obs_ctl(), 8'b0);
            end
            tick();
        end
        run_div("rmb_restart");
    endtask

    task automatic test_random();
        logic [7:0] exp;
        logic [5:0] fexp;
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 49) == 0);
            if (rst) begin
                hif.EX_div_start = 0;
                k = -1;
            end
            #1;
            exp = ref_ctl();
            fexp = {ref_fwd(hif.EX_rs_addr), ref_fwd(hif.EX_rt_addr)};
            n_cmp++;
            if (obs_ctl() !== exp) begin
                n_bad++;
                $display("FAIL rand_ctl i=%0d k=%0d: got %b expected %b", i, k, obs_ctl(), exp);
            end
            n_cmp++;
            if ({hif.EX_fwd_rs_sel, hif.EX_fwd_rt_sel} !== fexp) begin
                n_bad++;
                $display("FAIL rand_fwd i=%0d: got %b expected %b", i,
                         {hif.EX_fwd_rs_sel, hif.EX_fwd_rt_sel}, fexp);
            end
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_div();
        test_div_load_use();
        test_branch_stall();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
